// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: two-stage pipelined WIDTH x WIDTH multiplier with valid/ready
// handshakes on both sides.
//   Stage 1: AND partial-product array reduced by a Wallace carry-save tree,
//            registered as a sum/carry pair.
//   Stage 2: final carry-propagate add, registered as the product.
// Build option: define MUL_SIGNED_EN for two's-complement operands (Baugh-Wooley
// partial products). Undefined gives a plain unsigned multiplier.
module mul_pipe_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Sout,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
`ifdef MUL_SIGNED_EN
    // One extra row carries the Baugh-Wooley constant ones.
    localparam int NR = WIDTH + 1;
`else
    localparam int NR = WIDTH;
`endif

    // Rows left after a number of 3:2 reduction levels.
    function automatic int rows_after(input int lvl);
        int c;
        c = NR;
        for (int i = 0; i < lvl; i++) begin
            if (c > 2) c = 2 * (c / 3) + (c % 3);
        end
        return c;
    endfunction

    // Levels needed to bring NR rows down to a sum/carry pair.
    function automatic int num_levels(input int rows);
        int c;
        int l;
        c = rows;
        l = 0;
        for (int i = 0; i < rows; i++) begin
            if (c > 2) begin
                c = 2 * (c / 3) + (c % 3);
                l = l + 1;
            end
        end
        return l;
    endfunction

    localparam int LEVELS = num_levels(NR);

    logic [PW-1:0] pp [NR];
    logic [PW-1:0] sum1_d, carry1_d;
    logic [PW-1:0] sum1_q, carry1_q;
    logic [PW-1:0] sout_q;
    logic          v1_q, v2_q, done_q;
    logic          en1, en2, xfer;

    genvar gi, gl;

    // Partial-product rows, each pre-shifted to its weight.
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
        logic [WIDTH-1:0] row;
`ifdef MUL_SIGNED_EN
        if (gi < WIDTH - 1) begin : g_lo
            assign row = {~(A[WIDTH-1] & B[gi]), A[WIDTH-2:0] & {(WIDTH-1){B[gi]}}};
        end else begin : g_msb
            assign row = {A[WIDTH-1] & B[gi], ~(A[WIDTH-2:0] & {(WIDTH-1){B[gi]}})};
        end
`else
        assign row = A & {WIDTH{B[gi]}};
`endif
        assign pp[gi] = PW'(row) << gi;
    end
`ifdef MUL_SIGNED_EN
    // Correction constants at bit WIDTH and bit 2*WIDTH-1.
    assign pp[WIDTH] = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
`endif

    // Wallace tree: each level compresses groups of three rows into two,
    // leftover rows pass straight through to the next level.
    for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
        localparam int RC = rows_after(gl);
        logic [PW-1:0] r [RC];
        if (gl == 0) begin : g_src
            for (gi = 0; gi < NR; gi++) begin : g_row
                assign r[gi] = pp[gi];
            end
        end else begin : g_red
            localparam int PC = rows_after(gl - 1);
            localparam int G  = PC / 3;
            for (gi = 0; gi < G; gi++) begin : g_csa
                logic [PW-1:0] x, y, z;
                assign x = g_lvl[gl-1].r[3*gi];
                assign y = g_lvl[gl-1].r[3*gi+1];
                assign z = g_lvl[gl-1].r[3*gi+2];
                assign r[2*gi]   = x ^ y ^ z;
                assign r[2*gi+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
            for (gi = 0; gi < PC % 3; gi++) begin : g_pass
                assign r[2*G+gi] = g_lvl[gl-1].r[3*G+gi];
            end
        end
    end

    assign sum1_d   = g_lvl[LEVELS].r[0];
    assign carry1_d = g_lvl[LEVELS].r[1];

    // Handshake: a stage may load when it is empty or its successor moves on.
    assign en2      = !v2_q || out_ready;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;
    assign xfer     = in_valid && en1;

    // Stage 1: capture the carry-save pair of an accepted operand pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            sum1_q   <= '0;
            carry1_q <= '0;
        end else if (en1) begin
            v1_q <= xfer;
            if (xfer) begin
                sum1_q   <= sum1_d;
                carry1_q <= carry1_d;
            end
        end
    end

    // Stage 2: resolve the pair into the product; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sout_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) sout_q <= sum1_q + carry1_q;
        end
    end

    // Completion pulse one cycle after a product is taken downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= v2_q && out_ready;
    end

    assign out_valid = v2_q;
    assign Sout      = sout_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Testbench for mul_pipe_unit: directed table vectors, hand-written handshake
// sequences, and a randomized run on 8- and 16-bit instances against a queue
// based product model.
module tb_mul_pipe_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic        in_ready8, out_valid8, done8;
    logic [7:0]  A8 = '0, B8 = '0;
    logic [15:0] Sout8;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1;
    logic        in_ready16, out_valid16, done16;
    logic [15:0] A16 = '0, B16 = '0;
    logic [31:0] Sout16;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mul_pipe_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .out_valid(out_valid8), .out_ready(out_ready8),
        .Sout(Sout8), .done(done8)
    );

    mul_pipe_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(A16), .B(B16), .out_valid(out_valid16), .out_ready(out_ready16),
        .Sout(Sout16), .done(done16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference product: plain integer arithmetic on w-bit operands.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input int w);
        longint sa, sb;
        logic [63:0] msk;
        msk = (64'd1 << w) - 64'd1;
        sa  = longint'(a & msk);
        sb  = longint'(b & msk);
`ifdef MUL_SIGNED_EN
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: products accepted but not yet consumed, in order.
    logic [63:0] q8[$];
    logic [63:0] q16[$];
    logic        pc8 = 0, ps8 = 0, pc16 = 0, ps16 = 0;
    logic [15:0] pv8 = '0;
    logic [31:0] pv16 = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q8.delete(); q16.delete();
                pc8 = 0; ps8 = 0; pc16 = 0; ps16 = 0;
            end else begin
                chk("rdy8", 64'(in_ready8), 64'(out_ready8 || q8.size() < 2));
                chk("done8", 64'(done8), 64'(pc8));
                if (ps8) begin
                    chk("hold_v8", 64'(out_valid8), 64'd1);
                    chk("hold_s8", 64'(Sout8), 64'(pv8));
                end
                if (q8.size() == 0) chk("idle_v8", 64'(out_valid8), 64'd0);
                if (out_valid8 && out_ready8 && q8.size() > 0)
                    chk("prod8", 64'(Sout8), q8.pop_front());
                pc8 = out_valid8 && out_ready8;
                ps8 = out_valid8 && !out_ready8;
                pv8 = Sout8;
                if (in_valid8 && in_ready8) q8.push_back(ref_mul(64'(A8), 64'(B8), 8));

                chk("rdy16", 64'(in_ready16), 64'(out_ready16 || q16.size() < 2));
                chk("done16", 64'(done16), 64'(pc16));
                if (ps16) begin
                    chk("hold_v16", 64'(out_valid16), 64'd1);
                    chk("hold_s16", 64'(Sout16), 64'(pv16));
                end
                if (q16.size() == 0) chk("idle_v16", 64'(out_valid16), 64'd0);
                if (out_valid16 && out_ready16 && q16.size() > 0)
                    chk("prod16", 64'(Sout16), q16.pop_front());
                pc16 = out_valid16 && out_ready16;
                ps16 = out_valid16 && !out_ready16;
                pv16 = Sout16;
                if (in_valid16 && in_ready16) q16.push_back(ref_mul(64'(A16), 64'(B16), 16));
            end
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int k;
        logic [15:0] snap;

`ifdef MUL_SIGNED_EN
        tbl[0] = '{8'hFF, 8'hFF, 16'h0001};
        tbl[4] = '{8'h80, 8'hFF, 16'h0080};
        tbl[5] = '{8'h7F, 8'h80, 16'hC080};
`else
        tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
        tbl[4] = '{8'h80, 8'hFF, 16'h7F80};
        tbl[5] = '{8'h7F, 8'h80, 16'h3F80};
`endif
        tbl[1] = '{8'h03, 8'h05, 16'h000F};
        tbl[2] = '{8'h10, 8'h10, 16'h0100};
        tbl[3] = '{8'h00, 8'hAB, 16'h0000};

        // Reset release.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rdy8", 64'(in_ready8), 64'd1);
        chk("rst_ov8", 64'(out_valid8), 64'd0);
        chk("rst_s8", 64'(Sout8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_rdy16", 64'(in_ready16), 64'd1);
        chk("rst_ov16", 64'(out_valid16), 64'd0);
        chk("rst_s16", 64'(Sout16), 64'd0);
        chk("rst_done16", 64'(done16), 64'd0);
        $display("reset released");

        // Single product latency and done pulse.
        in_valid8 = 1; A8 = tbl[0].a; B8 = tbl[0].b; out_ready8 = 1;
        tick();
        in_valid8 = 0;
        chk("lat_e1_v", 64'(out_valid8), 64'd0);
        tick();
        chk("lat_e2_v", 64'(out_valid8), 64'd1);
        chk("lat_e2_s", 64'(Sout8), 64'(tbl[0].p));
        chk("lat_e2_d", 64'(done8), 64'd0);
        tick();
        chk("lat_e3_v", 64'(out_valid8), 64'd0);
        chk("lat_e3_d", 64'(done8), 64'd1);
        tick();
        chk("lat_e4_d", 64'(done8), 64'd0);
        $display("latency: %h*%h -> %h", tbl[0].a, tbl[0].b, tbl[0].p);

        // Back-to-back table vectors at full rate.
        for (int c = 0; c <= 7; c++) begin
            if (c < 6) begin
                in_valid8 = 1; A8 = tbl[c].a; B8 = tbl[c].b;
                chk("b2b_rdy", 64'(in_ready8), 64'd1);
            end else begin
                in_valid8 = 0;
            end
            tick();
            chk("b2b_v", 64'(out_valid8), 64'(c >= 1 && c <= 6));
            if (c >= 1 && c <= 6) begin
                chk("b2b_s", 64'(Sout8), 64'(tbl[c-1].p));
                $display("vec %0d: %h*%h -> %h (exp %h)", c - 1, tbl[c-1].a, tbl[c-1].b, Sout8, tbl[c-1].p);
            end
        end

        // Backpressure: five cycles of offered input with the sink stalled.
        out_ready8 = 0; k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid8 = 1; A8 = 8'(k + 1); B8 = 8'(k + 3);
            if (in_ready8) k++;
            tick();
        end
        chk("bp_accepts", 64'(k), 64'd2);
        chk("bp_rdy", 64'(in_ready8), 64'd0);
        chk("bp_v", 64'(out_valid8), 64'd1);
        snap = Sout8;
        chk("bp_s", 64'(snap), ref_mul(64'd1, 64'd3, 8));
        $display("stall: accepted %0d, holding %h", k, snap);
        in_valid8 = 0; out_ready8 = 1;
        repeat (4) tick();
        chk("bp_drain", 64'(q8.size()), 64'd0);

        // Reset with both stages full.
        out_ready8 = 0; k = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid8 = 1; A8 = 8'(c + 7); B8 = 8'(c + 9);
            if (in_ready8) k++;
            tick();
        end
        in_valid8 = 0;
        chk("mid_full", 64'(k), 64'd2);
        rst = 1;
        #1;
        chk("mid_ov", 64'(out_valid8), 64'd0);
        chk("mid_rdy", 64'(in_ready8), 64'd1);
        tick();
        rst = 0; out_ready8 = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_ov", 64'(out_valid8), 64'd0);
            chk("post_done", 64'(done8), 64'd0);
        end
        $display("mid-operation reset: pipeline flushed");

        // Randomized traffic on both widths with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            in_valid8   = ($urandom_range(0, 3) != 0);
            A8          = 8'($urandom);
            B8          = 8'($urandom);
            out_ready8  = ($urandom_range(0, 2) != 0);
            in_valid16  = ($urandom_range(0, 3) != 0);
            A16         = 16'($urandom);
            B16         = 16'($urandom);
            out_ready16 = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid8 = 0; in_valid16 = 0; out_ready8 = 1; out_ready16 = 1;
        repeat (4) tick();
        chk("rnd_drain8", 64'(q8.size()), 64'd0);
        chk("rnd_drain16", 64'(q16.size()), 64'd0);
        $display("random run complete");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
